fractal_scanout: RTL
====================

Name: fractal_scanout

Overview:
- Display-side reader for the Julia-set framebuffer. The fractal calculator writes one escape count per pixel into a double-buffered 640x480 framebuffer; this block reads that buffer back.
- Generates 640x480@60 VGA timing, issues framebuffer reads in raster order and maps each escape count to RGB. Escape count MAX_ITER (the in-set value) maps to black.
- Provides a vblank buffer-swap handshake so the calculator can hand over a finished frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- ITER_W, 7, escape-count width
- MAX_ITER, 99, escape count meaning "did not escape"
- RD_LAT, 2, framebuffer read latency in clocks (1..4)
- ADDR_W, 20, framebuffer address width (two buffers of 307200 words)

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scanout enable
- fb_rd_en  out  1  read strobe
- fb_rd_addr  out  ADDR_W  read address
- fb_rd_data  in  ITER_W  escape count, valid RD_LAT clocks after fb_rd_en
- swap_req  in  1  level; calculator has finished the back buffer
- swap_ack  out  1  one-clock pulse; swap applied
- front_buf  out  1  buffer currently displayed
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  active-video qualifier
- r, g, b  out  8 each  pixel colour
- frame_start  out  1  one-clock pulse aligned with first active pixel

Behaviour:
- Reset values (asynchronous, all outputs):
  - h_cnt = 0, v_cnt = 0, front_buf = 0
  - hsync = 1, vsync = 1, de = 0
  - r = g = b = 0, fb_rd_en = 0, fb_rd_addr = 0, swap_ack = 0, frame_start = 0
  - Pipeline valid bits cleared.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments on each h_cnt wrap, runs 0..524 and wraps to 0.
  - Counters advance only while enable = 1.
- Stage 0 (counter cycle):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - fb_rd_en = active.
  - fb_rd_addr = front_buf*307200 + v_cnt*640 + h_cnt. Computed with an incrementing row-base register, no multiplier.
  - hs_raw = 0 for h_cnt in 656..751.
  - vs_raw = 0 for v_cnt in 490..491.
- Pipeline alignment:
  - active, hs_raw and vs_raw pass through a delay line of RD_LAT+1 registers.
  - The colour register stage is the final stage.
  - Result: hsync, vsync, de, r, g, b all change on the same edge, RD_LAT+1 clocks after the counter cycle that produced them.
- Colour map (registered, stab = fb_rd_data):
  - stab >= MAX_ITER → 0,0,0.
  - Otherwise s8 = {stab,1'b0}; r = s8; g = 255 − s8; b = {stab[3:0],4'h0}.
  - de = 0 → r = g = b = 0.
- frame_start: pulses with the de output of pixel (0,0).
- Swap handshake:
  - Evaluated only in the cycle where v_cnt == V_ACTIVE+V_FP and h_cnt == 0, with enable = 1.
  - If swap_req = 1 in that cycle: front_buf toggles and swap_ack pulses for exactly that clock's next cycle.
  - Otherwise there is no change.
  - swap_req seen at any other time is ignored until the next evaluation point.
  - The calculator must drop swap_req after swap_ack; a still-high swap_req at the next frame causes another swap.
  - front_buf never changes during the active region.
- enable = 0:
  - Counters freeze at their current values; fb_rd_en = 0.
  - The delay line keeps shifting with inactive values, so after RD_LAT+1 clocks: de = 0, hsync = 1, vsync = 1, rgb = 0.
  - On re-enable, counting resumes from the frozen position (no resync).
- Reset mid-frame: immediate return to reset values, with no read issued in the reset cycle. The first read after release is address front_buf*307200 = 0.
- Unused fb_rd_data: ignored when the delayed active bit = 0.

Decomposition:
- Shared package fractal_pkg:
  - IMG_W = 640, IMG_H = 480, MAX_ITER = 99, ITER_W, FB_WORDS = 307200.
  - rgb_t struct {r,g,b}.
  - This package is shared with the calculator.
- Sub-module vga_timing: h_cnt/v_cnt, active, hs_raw, vs_raw, swap-evaluation strobe.
- Address generation, delay line, colour map and handshake logic stay in fractal_scanout.

Test Plan:
- Reset then enable = 1: first fb_rd_en at cycle 0 with addr 0; addr 639 at cycle 639; fb_rd_en low for h_cnt 640..799; line 1 starts at addr 640.
- Timing: hsync low exactly 96 clocks, first at counter 656 (output RD_LAT+1 later); vsync low on lines 490–491; period 800x525 = 420000 clocks per frame.
- Colour with RD_LAT = 2: stab = 0 → (0,255,0); stab = 10 → (20,235,160); stab = 99 → (0,0,0). Each appears RD_LAT+1 clocks after its read.
- swap_req high from line 300: swap_ack pulses at v = 490, h = 0; front_buf = 1; next frame's first address = 307200.
- swap_req pulsed for one cycle mid-frame → no swap, no ack.
- enable dropped at h = 100, v = 5 for 50 clocks: outputs idle after 3 clocks; after re-enable, next read address = 5*640 + 100. rst_n pulsed mid-line: all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/fractal_pkg.sv
// Definitions shared by the Julia-set calculator and the framebuffer scanout.
package fractal_pkg;

    localparam int IMG_W    = 640;
    localparam int IMG_H    = 480;
    localparam int MAX_ITER = 99;
    localparam int ITER_W   = 7;
    localparam int FB_WORDS = IMG_W * IMG_H;
    localparam int CNT_W    = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/fractal_scanout_vga_timing.sv
// Raster position counters plus the raw sync/active decode for the current position.
module vga_timing
    import fractal_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             line_end,
    output logic             frame_end,
    output logic             swap_eval
);

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_SWAP = CNT_W'(V_ACTIVE + V_FP);

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (enable) begin
            if (line_end) begin
                h_q <= '0;
                v_q <= frame_end ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    always_comb begin
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        active    = (h_q < H_ACT) && (v_q < V_ACT);
        hs_raw    = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_raw    = !((v_q >= VS_BEG) && (v_q < VS_END));
        swap_eval = enable && (v_q == V_SWAP) && (h_q == '0);
    end

    assign h_cnt = h_q;
    assign v_cnt = v_q;

endmodule

// File: rtl/fractal_scanout.sv
// Framebuffer scanout: raster reads, escape-count colour map, VGA syncs and
// the vblank front/back buffer swap handshake.
module fractal_scanout
    import fractal_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ITER_W   = 7,
    parameter int MAX_ITER = 99,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [ITER_W-1:0] fb_rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              frame_start
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_WORDS);
    localparam logic [ITER_W-1:0] IN_SET    = ITER_W'(MAX_ITER);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic             line_end;
    logic             frame_end;
    logic             swap_eval;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw),
        .line_end  (line_end),
        .frame_end (frame_end),
        .swap_eval (swap_eval)
    );

    // Bit 0 is the read-issue stage; bit RD_LAT lines up with the returning data.
    logic [RD_LAT:0]   act_q;
    logic [RD_LAT:0]   hs_q;
    logic [RD_LAT:0]   vs_q;
    logic [RD_LAT:0]   first_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              front_q;
    logic              ack_q;
    logic              de_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              fs_q;
    rgb_t              rgb_q;
    rgb_t              rgb_d;
    logic [7:0]        s8;

    always_comb begin
        s8    = 8'({fb_rd_data, 1'b0});
        rgb_d = '0;
        if (act_q[RD_LAT] && (fb_rd_data < IN_SET)) begin
            rgb_d.r = s8;
            rgb_d.g = 8'hFF - s8;
            rgb_d.b = {fb_rd_data[3:0], 4'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= '0;
            hs_q       <= '1;
            vs_q       <= '1;
            first_q    <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            front_q    <= 1'b0;
            ack_q      <= 1'b0;
            de_q       <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            act_q   <= {act_q[RD_LAT-1:0], enable && active};
            hs_q    <= {hs_q[RD_LAT-1:0], !enable || hs_raw};
            vs_q    <= {vs_q[RD_LAT-1:0], !enable || vs_raw};
            first_q <= {first_q[RD_LAT-1:0], enable && active && (h_cnt == '0) && (v_cnt == '0)};
            if (enable) begin
                addr_q <= row_base_q + ADDR_W'(h_cnt);
            end
            // Row base reloads at frame wrap, so a vblank swap takes effect on the next frame.
            if (enable && line_end) begin
                row_base_q <= frame_end ? (front_q ? BUF1_BASE : '0) : row_base_q + ROW_STEP;
            end
            ack_q <= swap_eval && swap_req;
            if (swap_eval && swap_req) begin
                front_q <= !front_q;
            end
            de_q    <= act_q[RD_LAT];
            hsync_q <= hs_q[RD_LAT];
            vsync_q <= vs_q[RD_LAT];
            fs_q    <= first_q[RD_LAT];
            rgb_q   <= rgb_d;
        end
    end

    assign fb_rd_en    = act_q[0];
    assign fb_rd_addr  = addr_q;
    assign swap_ack    = ack_q;
    assign front_buf   = front_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign frame_start = fs_q;

endmodule
